neuron_scheduler: RTL

- Time-multiplexes one shared combinational `neuron` datapath across NUM_NEURONS logical output neurons for a single input spike vector.
- Holds per-neuron weight sets and evaluates them one per cycle against a latched spike vector.
- Collects the per-neuron fire bits and reports the winner-take-all result: the lowest-index neuron that fired.
- Sits between the input spike source and the layer output. The shared `neuron` instance sits outside this block at the top level and connects through the nrn_* ports.

---
 rtl/neuron_scheduler_pkg.sv | 28 ++
 rtl/neuron.sv | 36 +++
 rtl/neuron_weight_bank.sv | 41 ++++
 rtl/neuron_scheduler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/neuron_scheduler_pkg.sv
// neuron_scheduler_pkg
//   Shared types and constants for the time-multiplexed neuron scheduler:
//   FSM state encoding, default geometry, the firing threshold used by the
//   shared neuron datapath, and an index-width helper.
package neuron_scheduler_pkg;

    localparam int NUM_NEURONS_DEF = 4;
    localparam int NUM_SPIKES_DEF  = 8;
    localparam int WBITS_DEF       = 8;
    localparam int THRESHOLD       = 100;

    // Width of an index selecting one of n items (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NRN_IDX_W = idx_w(NUM_NEURONS_DEF);
    localparam int SYN_IDX_W = idx_w(NUM_SPIKES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [NUM_SPIKES_DEF-1:0][WBITS_DEF-1:0] weight_set_t;

endpackage

// File: rtl/neuron.sv
// neuron
//   Shared combinational integrate-and-fire datapath. Sums the weights of all
//   synapses whose input spike is set and fires when the sum reaches THRESHOLD.
//   Ports:
//     spikes_in  - input spike vector
//     weights    - one weight per synapse (unsigned)
//     spike_out  - 1 when the weighted sum >= THRESHOLD
module neuron
    import neuron_scheduler_pkg::*;
#(
    parameter int NUM_SPIKES = NUM_SPIKES_DEF,
    parameter int WBITS      = WBITS_DEF,
    parameter int THRESH     = THRESHOLD
) (
    input  logic [NUM_SPIKES-1:0]            spikes_in,
    input  logic [NUM_SPIKES-1:0][WBITS-1:0] weights,
    output logic                             spike_out
);

    // One guard bit above the worst-case sum so the threshold compare never wraps.
    localparam int SW = WBITS + idx_w(NUM_SPIKES) + 1;

    logic [SW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_SPIKES; i++) begin
            if (spikes_in[i]) begin
                sum = sum + SW'(weights[i]);
            end
        end
    end

    assign spike_out = (sum >= SW'(THRESH));

endmodule

// File: rtl/neuron_weight_bank.sv
// neuron_weight_bank
//   NUM_NEURONS x NUM_SPIKES x WBITS weight register file.
//   Ports:
//     clk, rst         - clock, synchronous active-high clear of all weights
//     we               - write one synapse weight (already range-checked)
//     wr_nrn, wr_syn   - write address (neuron, synapse)
//     wr_data          - weight value
//     rd_idx           - neuron whose full weight set is read
//     rd_set           - combinational read data
module neuron_weight_bank
    import neuron_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int NUM_SPIKES  = NUM_SPIKES_DEF,
    parameter int WBITS       = WBITS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [idx_w(NUM_NEURONS)-1:0]     wr_nrn,
    input  logic [idx_w(NUM_SPIKES)-1:0]      wr_syn,
    input  logic [WBITS-1:0]                  wr_data,
    input  logic [idx_w(NUM_NEURONS)-1:0]     rd_idx,
    output logic [NUM_SPIKES-1:0][WBITS-1:0]  rd_set
);

    logic [NUM_SPIKES-1:0][WBITS-1:0] bank_q [NUM_NEURONS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                bank_q[n] <= '0;
            end
        end else if (we) begin
            bank_q[wr_nrn][wr_syn] <= wr_data;
        end
    end

    assign rd_set = bank_q[rd_idx];

endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler
//   Time-multiplexes one external combinational neuron across NUM_NEURONS
//   logical neurons. A start latches the spike vector, then one neuron weight
//   set is evaluated per cycle; fire bits are collected and the lowest-index
//   firing neuron is reported as winner. With INHIBIT=1 the pass stops at the
//   first neuron that fires.
//   Ports:
//     clk, rst                       - clock, synchronous active-high reset
//     start, spikes_in               - begin a pass, spike vector to latch
//     cfg_we/cfg_nrn/cfg_syn/cfg_wdata - single-synapse weight write (IDLE only)
//     cfg_err                        - one-cycle pulse, write was rejected
//     nrn_spikes_in, nrn_weights     - operands to the shared neuron
//     nrn_spike_out                  - fire result from the shared neuron
//     busy, done                     - evaluating / one-cycle results-valid pulse
//     fired, winner, winner_valid    - results of the last pass
module neuron_scheduler
    import neuron_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int NUM_SPIKES  = NUM_SPIKES_DEF,
    parameter int WBITS       = WBITS_DEF,
    parameter bit INHIBIT     = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NUM_SPIKES-1:0]             spikes_in,
    input  logic                              cfg_we,
    input  logic [idx_w(NUM_NEURONS)-1:0]     cfg_nrn,
    input  logic [idx_w(NUM_SPIKES)-1:0]      cfg_syn,
    input  logic [WBITS-1:0]                  cfg_wdata,
    output logic                              cfg_err,
    output logic [NUM_SPIKES-1:0]             nrn_spikes_in,
    output logic [NUM_SPIKES-1:0][WBITS-1:0]  nrn_weights,
    input  logic                              nrn_spike_out,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_NEURONS-1:0]            fired,
    output logic [idx_w(NUM_NEURONS)-1:0]     winner,
    output logic                              winner_valid
);

    localparam int NW = idx_w(NUM_NEURONS);
    localparam int SY = idx_w(NUM_SPIKES);
    localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);
    // One extra bit so the limit itself is representable for power-of-two sizes.
    localparam logic [NW:0]   NRN_LIM  = (NW+1)'(NUM_NEURONS);
    localparam logic [SY:0]   SYN_LIM  = (SY+1)'(NUM_SPIKES);

    state_e                  state_q, state_d;
    logic [NW-1:0]           idx_q, idx_d;
    logic [NUM_SPIKES-1:0]   spikes_q, spikes_d;
    logic [NUM_NEURONS-1:0]  fired_q, fired_d;
    logic [NW-1:0]           winner_q, winner_d;
    logic                    wv_q, wv_d;
    logic                    err_q, err_d;
    logic                    wr_en;
    logic                    cfg_ok;

    assign cfg_ok = ({1'b0, cfg_nrn} < NRN_LIM) && ({1'b0, cfg_syn} < SYN_LIM);

    neuron_weight_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .NUM_SPIKES  (NUM_SPIKES),
        .WBITS       (WBITS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_nrn  (cfg_nrn),
        .wr_syn  (cfg_syn),
        .wr_data (cfg_wdata),
        .rd_idx  (idx_q),
        .rd_set  (nrn_weights)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        spikes_d = spikes_q;
        fired_d  = fired_q;
        winner_d = winner_q;
        wv_d     = wv_q;
        err_d    = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // A write in the same cycle as start lands before the first
                // EVAL edge reads the bank, so the pass sees the new weight.
                wr_en = cfg_we && cfg_ok;
                err_d = cfg_we && !cfg_ok;
                if (start) begin
                    spikes_d = spikes_in;
                    fired_d  = '0;
                    winner_d = '0;
                    wv_d     = 1'b0;
                    idx_d    = '0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                err_d          = cfg_we;
                fired_d[idx_q] = nrn_spike_out;
                if (nrn_spike_out && !wv_q) begin
                    winner_d = idx_q;
                    wv_d     = 1'b1;
                end
                if ((idx_q == LAST_IDX) || (INHIBIT && nrn_spike_out)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                err_d   = cfg_we;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            spikes_q <= '0;
            fired_q  <= '0;
            winner_q <= '0;
            wv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            spikes_q <= spikes_d;
            fired_q  <= fired_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            err_q    <= err_d;
        end
    end

    assign nrn_spikes_in = spikes_q;
    assign busy          = (state_q == EVAL);
    assign done          = (state_q == DONE);
    assign cfg_err       = err_q;
    assign fired         = fired_q;
    assign winner        = winner_q;
    assign winner_valid  = wv_q;

endmodule
